swap_reg_file: RTL
==================

Name: swap_reg_file

Overview:
Parametrised successor to the team's single-port register file. Provides multiple asynchronous read ports and one synchronous write port. Adds a post-reset hardware clear sequence and an atomic two-entry swap engine with a req/ready/done handshake. It is the storage core that the memory-swapper control logic drives directly.

Parameters:
ADDR_WIDTH, 7, address bits; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 8, bits per entry
NUM_RD_PORTS, 2, number of independent asynchronous read ports (>=1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
we  input  1  external write enable
address_w  input  ADDR_WIDTH  external write address
data_w  input  DATA_WIDTH  external write data
address_r  input  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
data_r  output  NUM_RD_PORTS*DATA_WIDTH  packed read data, same packing
swap_req  input  1  request to swap two entries
swap_addr_a  input  ADDR_WIDTH  first swap address
swap_addr_b  input  ADDR_WIDTH  second swap address
swap_ready  output  1  swap request will be accepted this cycle
swap_busy  output  1  swap in progress
swap_done  output  1  one-cycle pulse when a swap completes
init_done  output  1  high once the post-reset clear has finished

Behaviour:
- States: CLEAR, IDLE, WR_A, WR_B. Reset state is CLEAR.
- Reset values: clear counter=0, init_done=0, swap_done=0, swap_busy=0, swap_ready=0. rst held high keeps the FSM in CLEAR with counter=0.
- CLEAR: one entry per cycle, mem[cnt]<=0, cnt increments.
  - After the edge that writes entry DEPTH-1, go to IDLE and set init_done=1.
  - First cycle with init_done=1 comes exactly DEPTH cycles after rst deasserts.
  - External we and swap_req are ignored in CLEAR.
  - Every data_r port is forced to 0 while init_done=0.
- Reads: data_r[i] = mem[address_r[i]], combinational, zero latency, on every port independently.
  - During a swap, reads return current contents. After WR_A commits, entry a already holds old b while b still holds old b.
- External write: honoured only when state==IDLE and init_done=1; mem[address_w]<=data_w at the edge. we in WR_A/WR_B/CLEAR is silently dropped.
- swap_ready = init_done && state==IDLE (combinational). swap_busy = (state==WR_A || state==WR_B).
- Swap acceptance: swap_req && swap_ready at an edge.
  - Latch a=swap_addr_a and b=swap_addr_b.
  - Capture tmp_a=mem[a] and tmp_b=mem[b], with forwarding: if we is also honoured at the same edge and address_w matches, the captured value is data_w.
  - The same-edge external write is still performed.
  - Next state WR_A.
- WR_A: mem[a]<=tmp_b; next state WR_B.
- WR_B: mem[b]<=tmp_a; next state IDLE; swap_done registered high for exactly the following cycle.
- Swap latency: request edge to swap_done high = 3 cycles. A new swap may be accepted in the cycle swap_done is high.
- a==b: full 3-cycle sequence still runs; contents unchanged; swap_done pulses.
- swap_req while not ready is ignored, not queued. The requester must hold it until swap_ready.
- rst mid-swap: abort immediately to CLEAR. No swap_done pulse; all contents cleared.
- Swap writes use the single internal write port, so memory has exactly one write per cycle. Infers as distributed RAM.

Test Plan:
- Init: rst high 2 cycles then low, DEPTH=128 -> init_done rises after exactly 128 cycles. data_r=0 throughout; all entries read 0 afterwards.
- Write/multi-read: write 0x11@3, 0x22@9; address_r ports={3,9} -> data_r={0x11,0x22} the cycle after each write edge. Same address on both ports returns the same value.
- Swap: mem[3]=0x11, mem[9]=0x22; swap_req a=3 b=9.
  - swap_busy high for 2 cycles; swap_done pulses at request+3.
  - Final contents mem[3]=0x22, mem[9]=0x11.
  - Intermediate cycle reads mem[3]=0x22, mem[9]=0x22.
- Blocked inputs: we to address 5 during swap_busy -> dropped, mem[5] unchanged. swap_req during busy -> ignored, no second swap_done.
- Simultaneous write+swap: in IDLE, we address 3 data 0x55 plus swap 3<->9 (mem[9]=0x22) -> final mem[3]=0x22, mem[9]=0x55. Also a==b=7 -> contents unchanged, swap_done pulses.
- Reset mid-swap: assert rst in WR_A -> no swap_done; init_done drops to 0; clear reruns; all entries 0 after 128 cycles.

Source files
------------

// File: rtl/swap_reg_file_if.sv
// Bus bundle for swap_reg_file: external write port, packed read ports and
// the swap request/status handshake.
interface swap_reg_file_if #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_RD_PORTS = 2
);
    logic                               we;
    logic [ADDR_WIDTH-1:0]              address_w;
    logic [DATA_WIDTH-1:0]              data_w;
    logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] address_r;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] data_r;
    logic                               swap_req;
    logic [ADDR_WIDTH-1:0]              swap_addr_a;
    logic [ADDR_WIDTH-1:0]              swap_addr_b;
    logic                               swap_ready;
    logic                               swap_busy;
    logic                               swap_done;
    logic                               init_done;

    modport master (
        output we, address_w, data_w, address_r, swap_req, swap_addr_a, swap_addr_b,
        input  data_r, swap_ready, swap_busy, swap_done, init_done
    );

    modport slave (
        input  we, address_w, data_w, address_r, swap_req, swap_addr_a, swap_addr_b,
        output data_r, swap_ready, swap_busy, swap_done, init_done
    );
endinterface

// File: rtl/swap_reg_file.sv
// Multi-read, single-write register file with a post-reset clear sweep and
// an atomic two-entry swap engine sharing the one internal write port.
module swap_reg_file #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_RD_PORTS = 2
) (
    input  logic           clk,
    input  logic           rst,
    swap_reg_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {CLEAR, IDLE, WR_A, WR_B} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  swap_done_q, swap_done_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  ext_we;
    logic                  swap_ready;

    assign swap_ready     = init_done_q && (state_q == IDLE);
    assign ext_we         = bus.we && swap_ready;
    assign bus.swap_ready = swap_ready;
    assign bus.swap_busy  = (state_q == WR_A) || (state_q == WR_B);
    assign bus.swap_done  = swap_done_q;
    assign bus.init_done  = init_done_q;

    always_comb begin
        bus.data_r = '0;
        if (init_done_q) begin
            for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
                bus.data_r[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem_q[bus.address_r[i*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        swap_done_d = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        tmp_a_d     = tmp_a_q;
        tmp_b_d     = tmp_b_q;
        wr_en       = 1'b0;
        wr_addr     = cnt_q;
        wr_data     = '0;
        unique case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
                cnt_d   = cnt_q + ONE;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (ext_we) begin
                    wr_en   = 1'b1;
                    wr_addr = bus.address_w;
                    wr_data = bus.data_w;
                end
                if (bus.swap_req && swap_ready) begin
                    a_d = bus.swap_addr_a;
                    b_d = bus.swap_addr_b;
                    // Capture forwards a same-edge external write so the swap sees it.
                    tmp_a_d = (ext_we && bus.address_w == bus.swap_addr_a) ? bus.data_w
                                                                           : mem_q[bus.swap_addr_a];
                    tmp_b_d = (ext_we && bus.address_w == bus.swap_addr_b) ? bus.data_w
                                                                           : mem_q[bus.swap_addr_b];
                    state_d = WR_A;
                end
            end
            WR_A: begin
                wr_en   = 1'b1;
                wr_addr = a_q;
                wr_data = tmp_b_q;
                state_d = WR_B;
            end
            WR_B: begin
                wr_en       = 1'b1;
                wr_addr     = b_q;
                wr_data     = tmp_a_q;
                swap_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            swap_done_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            tmp_a_q     <= '0;
            tmp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            swap_done_q <= swap_done_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tmp_a_q     <= tmp_a_d;
            tmp_b_q     <= tmp_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_addr] <= wr_data;
        end
    end
endmodule
